mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width; memory depth is 2**ADDR_W x 16 bits.
REQ-002 Parameter READ_LAT, default 2: cycles from read-request sample to data valid; legal range 1..4.
REQ-003 Parameter INIT_WORDS, default 16: number of words loaded from the internal boot table after reset; legal range 1..2**ADDR_W.
REQ-004 Port Clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port Reset  in  1: asynchronous, active-high reset.
REQ-006 Port address  in  ADDR_W: word address of the request.
REQ-007 Port data  in  16: write data, sampled with wren.
REQ-008 Port rden  in  1: read request, level-sampled each edge.
REQ-009 Port wren  in  1: write request, level-sampled each edge.
REQ-010 Port readout  out  16: registered read data; holds the last read value.
REQ-011 Port ready  out  1: one-cycle completion pulse for every accepted request.
REQ-012 Port busy  out  1: high while the boot load is in progress or a read is in flight.
REQ-013 Port err  out  1: sticky flag, set on an illegal simultaneous rden and wren.

Function
REQ-014 The state machine SHALL have states INIT, IDLE and RD_WAIT.
REQ-015 INIT: one word per cycle; word i (0..INIT_WORDS-1) written with the boot table entry; default table = 16'hA500 + i; busy=1; rden/wren ignored.
REQ-016 INIT -> IDLE on the edge that writes word INIT_WORDS-1; busy drops in the first IDLE cycle.
REQ-017 IDLE, wren=1, rden=0 at edge N: mem[address] <= data at edge N; ready=1 for the cycle after edge N; stay in IDLE.
REQ-018 IDLE, rden=1, wren=0 at edge N: address captured; readout <= mem[captured address] and ready=1 for exactly the cycle after edge N+READ_LAT-1.
REQ-019 With READ_LAT=1, RD_WAIT is not entered; readout and ready update at edge N.
REQ-020 With READ_LAT>1: IDLE -> RD_WAIT at edge N; a down-counter loaded with READ_LAT-1 returns to IDLE when it reaches zero; busy=1 throughout RD_WAIT.
REQ-021 rden/wren asserted during RD_WAIT SHALL be ignored, not queued; the initiator must re-present the request after ready.
REQ-022 IDLE, rden=1 and wren=1 at the same edge: no memory access, err <= 1, ready pulses for one cycle.
REQ-023 A read of an address written at the previous edge SHALL return the new data.
REQ-024 Back-to-back writes on consecutive edges SHALL each be accepted, each with its own ready pulse.
REQ-025 readout SHALL change only on read completion and on reset, never on a write.
REQ-026 Addresses are used modulo 2**ADDR_W; there is no out-of-range error.
REQ-027 ready SHALL never be high for two consecutive cycles that belong to a single request.

Reset
REQ-028 While Reset=1, the block SHALL be in INIT with the load index at 0, readout=16'h0000, ready=0, busy=1 and err=0, independent of Clk.
REQ-029 Reset asserted mid-read or mid-load SHALL abort the operation with no ready pulse; the boot load restarts from word 0 after Reset deasserts.
REQ-030 Reset SHALL NOT clear memory words at index >= INIT_WORDS; those words retain their contents across reset.
REQ-031 err SHALL clear only on Reset.

Verification
REQ-032 Release reset, wait for busy=0 (16 cycles), read address 3 -> readout=16'hA503 and a single ready pulse 2 cycles after the request edge.
REQ-033 Write 16'h1234 to address 10'h200, read the same address on the next edge -> readout=16'h1234; two ready pulses in total.
REQ-034 Assert rden=1 and wren=1 together in IDLE -> err=1 that stays set, the addressed memory word is unchanged, and one ready pulse.
REQ-035 Issue a read, then a write to address 5 during RD_WAIT -> the write is ignored, and a later read of address 5 returns 16'hA505.
REQ-036 Write 16'hBEEF to address 100, pulse Reset during a read -> no ready pulse for the read, the boot load reruns, and a read of address 100 returns 16'hBEEF.
REQ-037 With READ_LAT=1 and READ_LAT=4, issue a read at edge N -> ready appears after edge N and after edge N+3 respectively.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port 16-bit word memory with a boot-table preload, fixed-latency reads,
// a one-cycle completion pulse per accepted request, and a sticky collision flag.
module mem_responder #(
   parameter int ADDR_W     = 10,
   parameter int READ_LAT   = 2,
   parameter int INIT_WORDS = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [15:0]       data,
   input  logic              rden,
   input  logic              wren,
   output logic [15:0]       readout,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD_WAIT} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INIT_WORDS - 1);
   localparam logic [2:0]        CNT_LOAD = 3'(READ_LAT - 1);

   logic [15:0]       mem_q [2**ADDR_W];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [15:0]       readout_q, readout_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [15:0]       mem_wdata;

   function automatic logic [15:0] boot_word(input logic [ADDR_W-1:0] i);
      return 16'hA500 + 16'(i);
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_addr_d = rd_addr_q;
      cnt_d     = cnt_q;
      readout_d = readout_q;
      ready_d   = 1'b0;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_waddr = idx_q;
      mem_wdata = boot_word(idx_q);
      case (state_q)
         S_INIT: begin
            mem_we = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (rden && wren) begin
               // Collision: no access at all, but still acknowledged.
               err_d   = 1'b1;
               ready_d = 1'b1;
            end else if (wren) begin
               mem_we    = 1'b1;
               mem_waddr = address;
               mem_wdata = data;
               ready_d   = 1'b1;
            end else if (rden) begin
               if (READ_LAT == 1) begin
                  readout_d = mem_q[address];
                  ready_d   = 1'b1;
               end else begin
                  rd_addr_d = address;
                  cnt_d     = CNT_LOAD;
                  state_d   = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            // Requests arriving here are dropped; the counter alone decides completion.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == 3'd1) begin
               readout_d = mem_q[rd_addr_q];
               ready_d   = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_INIT;
         idx_q     <= '0;
         rd_addr_q <= '0;
         cnt_q     <= '0;
         readout_q <= 16'h0000;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_addr_q <= rd_addr_d;
         cnt_q     <= cnt_d;
         readout_q <= readout_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   // Storage is deliberately not reset so words above the boot range survive Reset.
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign readout = readout_q;
   assign ready   = ready_q;
   assign busy    = (state_q != S_IDLE);
   assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: READ_LAT=2 main instance plus READ_LAT=1/4 latency instances.
module tb_mem_responder;
   localparam int AW = 10;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic [AW-1:0] address = '0;
   logic [15:0]   data = '0;
   logic          rden = 1'b0;
   logic          wren = 1'b0;
   logic [15:0]   readout;
   logic          ready, busy, err;

   logic [AW-1:0] lat_addr = '0;
   logic [15:0]   zero16 = '0;
   logic          rd1 = 1'b0, rd4 = 1'b0, no_wr = 1'b0;
   logic [15:0]   readout1, readout4;
   logic          ready1, busy1, err1, ready4, busy4, err4;

   mem_responder #(.ADDR_W(AW), .READ_LAT(2), .INIT_WORDS(16)) u2 (
      .Clk(Clk), .Reset(Reset), .address(address), .data(data), .rden(rden), .wren(wren),
      .readout(readout), .ready(ready), .busy(busy), .err(err));

   mem_responder #(.ADDR_W(AW), .READ_LAT(1), .INIT_WORDS(16)) u1 (
      .Clk(Clk), .Reset(Reset), .address(lat_addr), .data(zero16), .rden(rd1), .wren(no_wr),
      .readout(readout1), .ready(ready1), .busy(busy1), .err(err1));

   mem_responder #(.ADDR_W(AW), .READ_LAT(4), .INIT_WORDS(16)) u4 (
      .Clk(Clk), .Reset(Reset), .address(lat_addr), .data(zero16), .rden(rd4), .wren(no_wr),
      .readout(readout4), .ready(ready4), .busy(busy4), .err(err4));

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] d;
      int          due;
   } exp_t;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] exp_last = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ready pulse of the main instance must match the oldest expectation.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ready: got ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("ready_readout", readout, mon_e.d);
               check("ready_cycle", cyc, mon_e.due);
            end
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ready: got no ready expected one at cycle %0d", sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   task automatic req(input logic r, input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                      input bit push, input logic [15:0] ed);
      exp_t e;
      @(negedge Clk);
      rden = r;
      wren = w;
      address = a;
      data = d;
      if (push) begin
         if (r && !w) begin
            e.d = ed;
            e.due = cyc + 2;
            exp_last = ed;
         end else begin
            e.d = exp_last;
            e.due = cyc + 1;
         end
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge Clk);
      rden = 1'b0;
      wren = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (sb.size() == 0 && !busy) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
   endtask

   task automatic wait_boot(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         n++;
         if (!busy) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, k1, k4, p1, p4;
      repeat (2) @(negedge Clk);
      check("rst_readout", readout, 16'h0000);
      check("rst_ready", ready, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_err", err, 1'b0);
      Reset = 1'b0;
      wait_boot(n);
      check("boot_cycles", n, 16);

      req(1'b1, 1'b0, 10'd3, 16'h0, 1'b1, 16'hA503);
      idle();
      check("busy_rd_wait", busy, 1'b1);
      drain();

      req(1'b0, 1'b1, 10'h200, 16'h1234, 1'b1, 16'h0);
      req(1'b1, 1'b0, 10'h200, 16'h0, 1'b1, 16'h1234);
      idle();
      drain();

      req(1'b1, 1'b1, 10'd7, 16'hDEAD, 1'b1, 16'h0);
      idle();
      check("err_set", err, 1'b1);
      drain();
      req(1'b1, 1'b0, 10'd7, 16'h0, 1'b1, 16'hA507);
      idle();
      drain();
      check("err_sticky", err, 1'b1);

      req(1'b1, 1'b0, 10'd9, 16'h0, 1'b1, 16'hA509);
      req(1'b0, 1'b1, 10'd5, 16'h5555, 1'b0, 16'h0);
      idle();
      drain();
      req(1'b1, 1'b0, 10'd5, 16'h0, 1'b1, 16'hA505);
      idle();
      drain();

      req(1'b0, 1'b1, 10'd20, 16'h1111, 1'b1, 16'h0);
      req(1'b0, 1'b1, 10'd21, 16'h2222, 1'b1, 16'h0);
      req(1'b0, 1'b1, 10'h3FF, 16'hC3C3, 1'b1, 16'h0);
      req(1'b1, 1'b0, 10'd20, 16'h0, 1'b1, 16'h1111);
      idle();
      drain();
      req(1'b1, 1'b0, 10'd21, 16'h0, 1'b1, 16'h2222);
      idle();
      drain();
      req(1'b1, 1'b0, 10'h3FF, 16'h0, 1'b1, 16'hC3C3);
      idle();
      drain();
      check("err_still_set", err, 1'b1);

      req(1'b0, 1'b1, 10'd100, 16'hBEEF, 1'b1, 16'h0);
      req(1'b0, 1'b1, 10'd2, 16'h7777, 1'b1, 16'h0);
      idle();
      drain();
      req(1'b1, 1'b0, 10'd4, 16'h0, 1'b0, 16'h0);
      @(negedge Clk);
      rden = 1'b0;
      Reset = 1'b1;
      #1;
      check("rst2_readout", readout, 16'h0000);
      check("rst2_ready", ready, 1'b0);
      check("rst2_busy", busy, 1'b1);
      check("rst2_err", err, 1'b0);
      exp_last = 16'h0000;
      @(negedge Clk);
      Reset = 1'b0;
      wait_boot(n);
      check("reboot_cycles", n, 16);
      req(1'b1, 1'b0, 10'd100, 16'h0, 1'b1, 16'hBEEF);
      idle();
      drain();
      req(1'b1, 1'b0, 10'd2, 16'h0, 1'b1, 16'hA502);
      idle();
      drain();

      @(negedge Clk);
      lat_addr = 10'd6;
      rd1 = 1'b1;
      rd4 = 1'b1;
      k1 = 0; k4 = 0; p1 = 0; p4 = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         rd1 = 1'b0;
         rd4 = 1'b0;
         if (ready1) begin p1++; if (k1 == 0) k1 = k; end
         if (ready4) begin p4++; if (k4 == 0) k4 = k; end
      end
      check("lat1_ready_at", k1, 1);
      check("lat4_ready_at", k4, 4);
      check("lat1_pulses", p1, 1);
      check("lat4_pulses", p4, 1);
      check("lat1_readout", readout1, 16'hA506);
      check("lat4_readout", readout4, 16'hA506);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
